// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use and taken-branch hazard resolution,
// data-memory wait stalls, saturating statistics and a memory-wait watchdog.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_busy,
  input  logic             clr_stats,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic             pcsrc,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wd_err
);

  typedef enum logic [1:0] {
    ACT_RUN     = 2'd0,
    ACT_LDSTALL = 2'd1,
    ACT_MEMWAIT = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_e;

  localparam int               BR_W    = $clog2(TIMEOUT + 1);
  localparam logic [BR_W-1:0]  BR_MAX  = BR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  logic    take;
  logic    lu;
  action_e action;

  action_e          state_q,     state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [BR_W-1:0]  busy_run_q,  busy_run_d;
  logic             wd_err_q,    wd_err_d;

  // Hazard detection; register 0 is hardwired so it can never cause a stall.
  always_comb begin
    take = mem_branch & mem_zero;
    lu   = ex_memread && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

  // Action decode and control outputs, purely combinational so they act this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    action      = ACT_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    pcsrc       = 1'b0;
    if (take) begin
      // A taken branch redirects fetch even if memory is busy this cycle.
      action = ACT_FLUSH;
      flush  = 1'b1;
      pcsrc  = 1'b1;
    end else if (mem_busy) begin
      action      = ACT_MEMWAIT;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (lu) begin
      // Hold PC and IF/ID, inject a bubble into EX; the load advances normally.
      action      = ACT_LDSTALL;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Next-state for the action history, statistics and watchdog.
  always_comb begin
    state_d     = action;
    stall_cnt_d = sat_inc(stall_cnt_q, action == ACT_LDSTALL);
    wait_cnt_d  = sat_inc(wait_cnt_q,  action == ACT_MEMWAIT);
    flush_cnt_d = sat_inc(flush_cnt_q, action == ACT_FLUSH);
    if (clr_stats) begin
      stall_cnt_d = '0;
      wait_cnt_d  = '0;
      flush_cnt_d = '0;
    end

    if (!mem_busy)
      busy_run_d = '0;
    else if (busy_run_q == BR_MAX)
      busy_run_d = busy_run_q;
    else
      busy_run_d = busy_run_q + BR_W'(1);

    // Set on the edge that brings the run to TIMEOUT; only reset clears it.
    wd_err_d = wd_err_q | (busy_run_d == BR_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACT_RUN;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      busy_run_q  <= '0;
      wd_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_run_q  <= busy_run_d;
      wd_err_q    <= wd_err_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign wait_cnt  = wait_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wd_err    = wd_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl, built with CNT_W=3 and TIMEOUT=4 so that
// counter saturation and the watchdog are reachable in a few cycles.
module tb_hazard_ctrl;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;

  // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, flush, pcsrc}
  localparam logic [6:0] C_RUN     = 7'b1111_000;
  localparam logic [6:0] C_LDSTALL = 7'b0011_100;
  localparam logic [6:0] C_MEMWAIT = 7'b0000_000;
  localparam logic [6:0] C_FLUSH   = 7'b1111_011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rt, ex_memread, mem_branch, mem_zero, mem_busy, clr_stats;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             idex_bubble, flush, pcsrc, wd_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, wait_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_busy(mem_busy),
    .clr_stats(clr_stats),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble), .flush(flush),
    .pcsrc(pcsrc), .state(state),
    .stall_cnt(stall_cnt), .wait_cnt(wait_cnt), .flush_cnt(flush_cnt),
    .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [6:0] exp);
    check(tag, 16'({pc_write, ifid_write, idex_write, exmem_write,
                    idex_bubble, flush, pcsrc}), 16'(exp));
  endtask

  task automatic check_regs(input string tag, input logic [1:0] st,
                            input int sc, input int wc, input int fc, input logic wd);
    check({tag, ".state"}, 16'(state), 16'(st));
    check({tag, ".stall"}, 16'(stall_cnt), 16'(sc));
    check({tag, ".wait"},  16'(wait_cnt), 16'(wc));
    check({tag, ".flush"}, 16'(flush_cnt), 16'(fc));
    check({tag, ".wd"},    16'(wd_err), 16'(wd));
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_busy = 1'b0; clr_stats = 1'b0;
  endtask

  // Load in EX writing $8, ID reads $8 through rs.
  task automatic drive_lu();
    idle();
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
  endtask

  // Advance one edge, then settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    check_ctl("reset.ctl", C_RUN);
    check_regs("reset", 2'd0, 0, 0, 0, 1'b0);
    tick();
    rst_n = 1'b1;

    // 1: load-use on rs
    drive_lu(); #1;
    check_ctl("lu_rs.ctl", C_LDSTALL);
    tick();
    check_regs("lu_rs", 2'd1, 1, 0, 0, 1'b0);
    idle(); #1;
    check_ctl("after_bubble.ctl", C_RUN);
    tick();
    check("after_bubble.state", 16'(state), 16'd0);

    // 2: $0 never stalls; rt ignored unless used
    idle(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; #1;
    check_ctl("rd_zero.ctl", C_RUN);
    idle(); ex_memread = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd3; #1;
    check_ctl("rt_unused.ctl", C_RUN);
    tick();
    check_regs("rt_unused", 2'd0, 1, 0, 0, 1'b0);
    id_uses_rt = 1'b1; #1;
    check_ctl("rt_used.ctl", C_LDSTALL);
    tick();
    check_regs("rt_used", 2'd1, 2, 0, 0, 1'b0);

    // 3: taken branch beats busy and load-use
    drive_lu(); mem_busy = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1; #1;
    check_ctl("flush_prio.ctl", C_FLUSH);
    tick();
    check_regs("flush_prio", 2'd3, 2, 0, 1, 1'b0);
    idle(); mem_branch = 1'b1; #1;
    check_ctl("not_taken.ctl", C_RUN);
    tick();

    // clr_stats overrides a concurrent increment
    drive_lu(); clr_stats = 1'b1; #1;
    check_ctl("clr_lu.ctl", C_LDSTALL);
    tick();
    check_regs("clr", 2'd1, 0, 0, 0, 1'b0);

    // 4: three busy cycles, then one load-use bubble
    for (int i = 0; i < 3; i++) begin
      idle(); mem_busy = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; #1;
      check_ctl($sformatf("busy%0d.ctl", i), C_MEMWAIT);
      tick();
      check($sformatf("busy%0d.wait", i), 16'(wait_cnt), 16'(i + 1));
    end
    drive_lu(); #1;
    check_ctl("lu_after_busy.ctl", C_LDSTALL);
    tick();
    check_regs("lu_after_busy", 2'd1, 1, 3, 0, 1'b0);

    // 5: watchdog fires on the 4th consecutive busy edge; wait_cnt saturates
    for (int i = 0; i < 5; i++) begin
      idle(); mem_busy = 1'b1;
      tick();
      check($sformatf("wd%0d.err", i), 16'(wd_err), 16'(i >= 3));
      check($sformatf("wd%0d.wait", i), 16'(wait_cnt), 16'((3 + i + 1 > 7) ? 7 : 3 + i + 1));
    end
    idle(); clr_stats = 1'b1;
    tick();
    check_regs("clr_keeps_wd", 2'd0, 0, 0, 0, 1'b1);
    idle();
    rst_n = 1'b0; #1;
    check("rst_clears_wd", 16'(wd_err), 16'd0);
    tick();
    rst_n = 1'b1;

    // 6: stall_cnt saturates at 7, then async reset mid-stall
    for (int i = 1; i <= 9; i++) begin
      drive_lu();
      tick();
      check($sformatf("sat%0d.stall", i), 16'(stall_cnt), 16'((i > 7) ? 7 : i));
    end
    #2;
    rst_n = 1'b0; #1;
    check_ctl("in_reset.ctl", C_LDSTALL);
    check_regs("async_rst", 2'd0, 0, 0, 0, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
